ps2_key_decoder: RTL and testbench

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

---
 rtl/ps2_key_decoder_pkg.sv | 25 ++
 rtl/ps2_key_decoder_evt_fifo.sv | 55 +++++
 rtl/ps2_key_decoder.sv | 192 +++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_key_decoder_pkg.sv
// Shared definitions for the PS/2 key decoder: scan-code constants,
// the decoded event record and the fetch-state encoding.
package ps2_key_decoder_pkg;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_RESEND = 8'hFE;
    localparam logic [7:0] PS2_ERR0   = 8'h00;
    localparam logic [7:0] PS2_ERRF   = 8'hFF;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    typedef enum logic {
        FETCH = 1'b0,
        WAIT  = 1'b1
    } fetch_state_t;

endpackage

// File: rtl/ps2_key_decoder_evt_fifo.sv
// First-word-fall-through event FIFO. A push into a full FIFO is accepted
// only when a pop frees a slot in the same cycle; otherwise drop_o flags it.
module ps2_evt_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       data_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   drop_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW:0]      count_q;
    logic             empty;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & ~do_push;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = ~empty;
    assign count_o = count_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: fetches bytes from ps2_if, folds E0/F0/E1 prefixes
// into key events, filters typematic repeats and queues events for a consumer.
module ps2_key_decoder
    import ps2_key_decoder_pkg::*;
#(
    parameter int unsigned EVT_DEPTH   = 4,
    parameter int unsigned DROP_REPEAT = 1,
    parameter int unsigned PREFIX_TO   = 50000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       fifo_empty,
    input  logic [7:0]                 fifo_data,
    output logic                       fifo_rd,
    output logic                       evt_valid,
    input  logic                       evt_ready,
    output logic [7:0]                 evt_code,
    output logic                       evt_ext,
    output logic                       evt_break,
    output logic [$clog2(EVT_DEPTH):0] evt_count,
    output logic                       overflow,
    input  logic                       clr_ovf,
    output logic                       err
);

    localparam int unsigned TW = $clog2(PREFIX_TO + 1);

    logic [1:0]   rst_sync_q;
    logic         run;
    fetch_state_t state_q, state_d;
    logic         byte_vld;
    logic         ext_q, ext_d;
    logic         brk_q, brk_d;
    logic [2:0]   skip_q, skip_d;
    logic [TW-1:0] to_q, to_d;
    logic         err_q, err_d;
    logic         ovf_q, ovf_d;
    logic         lm_ext_q, lm_ext_d;
    logic         lm_vld_q, lm_vld_d;
    logic [7:0]   lm_code_q, lm_code_d;
    logic         cand_vld;
    ps2_evt_t     cand;
    ps2_evt_t     head;
    logic         push;
    logic         drop;

    // Assertion is immediate; release reaches the FSM two clocks later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync_q <= '0;
        else      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign run = rst_sync_q[1];

    always_comb begin
        state_d = state_q;
        fifo_rd = 1'b0;
        case (state_q)
            FETCH: begin
                if (run && !fifo_empty) begin
                    fifo_rd = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT:    state_d = FETCH;
            default: state_d = FETCH;
        endcase
    end

    assign byte_vld = (state_q == WAIT);

    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        skip_d   = skip_q;
        to_d     = to_q;
        err_d    = 1'b0;
        cand_vld = 1'b0;
        cand     = {ext_q, brk_q, fifo_data};
        if (byte_vld) begin
            to_d = '0;
            if (skip_q != 3'd0) begin
                skip_d = skip_q - 3'd1;
            end else if (fifo_data == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (fifo_data == PS2_BRK) begin
                brk_d = 1'b1;
            end else if (fifo_data == PS2_PAUSE) begin
                cand_vld = 1'b1;
                cand     = {1'b1, 1'b0, PS2_PAUSE};
                ext_d    = 1'b0;
                brk_d    = 1'b0;
                skip_d   = 3'd7;
            end else if (fifo_data == PS2_ERR0 || fifo_data == PS2_ERRF) begin
                ext_d = 1'b0;
                brk_d = 1'b0;
                err_d = 1'b1;
            end else if ((fifo_data == PS2_BAT || fifo_data == PS2_ACK ||
                          fifo_data == PS2_RESEND) && !ext_q && !brk_q) begin
                cand_vld = 1'b0;
            end else begin
                cand_vld = 1'b1;
                ext_d    = 1'b0;
                brk_d    = 1'b0;
            end
        end else if (ext_q || brk_q || skip_q != 3'd0) begin
            if (to_q == TW'(PREFIX_TO - 1)) begin
                to_d   = '0;
                ext_d  = 1'b0;
                brk_d  = 1'b0;
                skip_d = 3'd0;
                err_d  = 1'b1;
            end else begin
                to_d = to_q + TW'(1);
            end
        end else begin
            to_d = '0;
        end
    end

    // A matching break re-arms the filter so the next press of that key passes.
    always_comb begin
        lm_ext_d  = lm_ext_q;
        lm_code_d = lm_code_q;
        lm_vld_d  = lm_vld_q;
        push      = 1'b0;
        if (cand_vld) begin
            if (DROP_REPEAT == 0) begin
                push = 1'b1;
            end else if (!cand.brk) begin
                if (!(lm_vld_q && lm_ext_q == cand.ext && lm_code_q == cand.code)) begin
                    push      = 1'b1;
                    lm_ext_d  = cand.ext;
                    lm_code_d = cand.code;
                    lm_vld_d  = 1'b1;
                end
            end else begin
                push = 1'b1;
                if (lm_ext_q == cand.ext && lm_code_q == cand.code) lm_vld_d = 1'b0;
            end
        end
    end

    assign ovf_d = (ovf_q & ~clr_ovf) | drop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FETCH;
            ext_q     <= 1'b0;
            brk_q     <= 1'b0;
            skip_q    <= 3'd0;
            to_q      <= '0;
            err_q     <= 1'b0;
            ovf_q     <= 1'b0;
            lm_ext_q  <= 1'b0;
            lm_code_q <= 8'h00;
            lm_vld_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ext_q     <= ext_d;
            brk_q     <= brk_d;
            skip_q    <= skip_d;
            to_q      <= to_d;
            err_q     <= err_d;
            ovf_q     <= ovf_d;
            lm_ext_q  <= lm_ext_d;
            lm_code_q <= lm_code_d;
            lm_vld_q  <= lm_vld_d;
        end
    end

    ps2_evt_fifo #(
        .DEPTH (EVT_DEPTH),
        .WIDTH ($bits(ps2_evt_t))
    ) u_evt_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .push_i  (push),
        .data_i  (cand),
        .pop_i   (evt_ready),
        .data_o  (head),
        .valid_o (evt_valid),
        .count_o (evt_count),
        .drop_o  (drop)
    );

    assign evt_code  = head.code;
    assign evt_ext   = head.ext;
    assign evt_break = head.brk;
    assign overflow  = ovf_q;
    assign err       = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Directed bench for ps2_key_decoder: a byte-queue model of ps2_if feeds the
// decoder, and popped events are collected and compared with hand-derived tables.
module tb_ps2_key_decoder;

    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_data = 8'h00;
    logic       fifo_rd;
    logic       evt_valid;
    logic       evt_ready = 1'b1;
    logic [7:0] evt_code;
    logic       evt_ext;
    logic       evt_break;
    logic [2:0] evt_count;
    logic       overflow;
    logic       clr_ovf = 1'b0;
    logic       err;

    int total = 0;
    int bad = 0;
    int err_cnt = 0;
    logic [7:0] src_q[$];
    logic [9:0] got[$];

    typedef struct {
        logic [95:0] bytes;
        int          n;
        logic [29:0] evs;
        int          nev;
        int          nerr;
    } vec_t;

    vec_t tbl[9];

    ps2_key_decoder #(
        .EVT_DEPTH   (4),
        .DROP_REPEAT (1),
        .PREFIX_TO   (TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd    (fifo_rd),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_break  (evt_break),
        .evt_count  (evt_count),
        .overflow   (overflow),
        .clr_ovf    (clr_ovf),
        .err        (err)
    );

    always #5 clk = ~clk;

    // ps2_if model: data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (fifo_rd && src_q.size() > 0) fifo_data <= src_q.pop_front();
        fifo_empty <= (src_q.size() == 0);
    end

    always @(negedge clk) begin
        if (evt_valid && evt_ready) got.push_back({evt_ext, evt_break, evt_code});
        if (err) err_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        src_q.push_back(b);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((src_q.size() != 0 || !fifo_empty) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            total++;
            bad++;
            $display("FAIL %s_drain: source not consumed within 200 cycles", name);
        end
        repeat (6) @(negedge clk);
    endtask

    function automatic logic [31:0] got_at(input int i);
        if (i < got.size()) return 32'(got[i]);
        return 32'hDEAD;
    endfunction

    initial begin
        int e0;
        logic [7:0] bt;

        // {ext,brk,code} events, left-aligned in evs
        tbl[0] = '{96'hE075E0F075,         5, {10'h275, 10'h375, 10'h000}, 2, 0};
        tbl[1] = '{96'h1C1C1CF01C1C,       6, {10'h01C, 10'h11C, 10'h01C}, 3, 0};
        tbl[2] = '{96'hE11477E1F014F07729, 9, {10'h2E1, 10'h029, 10'h000}, 2, 0};
        tbl[3] = '{96'hAAFAFE2D,           4, {10'h02D, 10'h000, 10'h000}, 1, 0};
        tbl[4] = '{96'hE00024,             3, {10'h024, 10'h000, 10'h000}, 1, 1};
        tbl[5] = '{96'hE0AA,               2, {10'h2AA, 10'h000, 10'h000}, 1, 0};
        tbl[6] = '{96'hE0F0AA,             3, {10'h3AA, 10'h000, 10'h000}, 1, 0};
        tbl[7] = '{96'hF0FF12,             3, {10'h012, 10'h000, 10'h000}, 1, 1};
        tbl[8] = '{96'h12,                 1, {10'h000, 10'h000, 10'h000}, 0, 0};

        repeat (2) @(negedge clk);
        chk("rst_fifo_rd", 32'(fifo_rd), 0);
        chk("rst_evt_valid", 32'(evt_valid), 0);
        chk("rst_evt_count", 32'(evt_count), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_err", 32'(err), 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // Make/break of 1C with latency measured from the final fetch
        evt_ready = 1'b0;
        got.delete();
        send(8'h1C);
        begin
            int n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!fifo_rd && n < 20);
            chk("lat_rd_seen", 32'(fifo_rd), 1);
        end
        @(negedge clk);
        chk("lat_valid_c1", 32'(evt_valid), 0);
        @(negedge clk);
        chk("lat_valid_c2", 32'(evt_valid), 1);
        chk("lat_head", {22'd0, evt_ext, evt_break, evt_code}, 32'h01C);
        evt_ready = 1'b1;
        send(8'hF0);
        send(8'h1C);
        drain("mb");
        chk("mb_count", got.size(), 2);
        chk("mb_ev0", got_at(0), 32'h01C);
        chk("mb_ev1", got_at(1), 32'h11C);

        for (int k = 0; k < 9; k++) begin
            got.delete();
            e0 = err_cnt;
            for (int i = 0; i < tbl[k].n; i++) begin
                bt = tbl[k].bytes[8*(tbl[k].n-1-i) +: 8];
                send(bt);
            end
            drain($sformatf("v%0d", k));
            chk($sformatf("v%0d_count", k), got.size(), tbl[k].nev);
            for (int i = 0; i < tbl[k].nev; i++)
                chk($sformatf("v%0d_ev%0d", k, i), got_at(i), 32'(tbl[k].evs[29-10*i -: 10]));
            chk($sformatf("v%0d_err", k), err_cnt - e0, tbl[k].nerr);
        end

        // Overflow: six makes into a depth-4 FIFO with the consumer stalled
        evt_ready = 1'b0;
        got.delete();
        send(8'h15); send(8'h16); send(8'h21); send(8'h22); send(8'h23); send(8'h26);
        drain("ovf");
        chk("ovf_count", 32'(evt_count), 4);
        chk("ovf_flag", 32'(overflow), 1);
        evt_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("ovf_pops", got.size(), 4);
        chk("ovf_ev0", got_at(0), 32'h015);
        chk("ovf_ev1", got_at(1), 32'h016);
        chk("ovf_ev2", got_at(2), 32'h021);
        chk("ovf_ev3", got_at(3), 32'h022);
        chk("ovf_sticky", 32'(overflow), 1);
        chk("ovf_empty", 32'(evt_count), 0);
        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);

        // Dangling E0 prefix times out once; the next byte is decoded fresh
        got.delete();
        e0 = err_cnt;
        send(8'hE0);
        drain("to");
        repeat (TO + 5) @(negedge clk);
        chk("to_err_once", err_cnt - e0, 1);
        chk("to_no_event", got.size(), 0);
        send(8'h1C);
        drain("to2");
        chk("to_next_count", got.size(), 1);
        chk("to_next_ev", got_at(0), 32'h01C);

        // Reset between F0 and 1C discards the pending break
        got.delete();
        send(8'hF0);
        drain("rs");
        rst = 1'b0;
        @(negedge clk);
        chk("rs_fifo_rd", 32'(fifo_rd), 0);
        chk("rs_evt_count", 32'(evt_count), 0);
        send(8'h1C);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rs_sync_hold", 32'(fifo_rd), 0);
        drain("rs2");
        chk("rs_count", got.size(), 1);
        chk("rs_ev", got_at(0), 32'h01C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
